// File: rtl/sfu_if.sv
`default_nettype none
//============================================================================
// Module : sfu_if
// Desc   : Operand/result bundle between an issuing stage and the sfu.
// Rev    : 1.0
//============================================================================
interface sfu_if;
  logic        start_i;
  logic [31:0] src1_i;
  logic [2:0]  selop_i;
  logic [31:0] Result_o;
  logic        stall_o;

  modport master (
    output start_i,
    output src1_i,
    output selop_i,
    input  Result_o,
    input  stall_o
  );

  modport slave (
    input  start_i,
    input  src1_i,
    input  selop_i,
    output Result_o,
    output stall_o
  );
endinterface
`default_nettype wire

// File: rtl/sfu.sv
`default_nettype none
//============================================================================
// Module : sfu
// Desc   : SIMT special function unit: 24-step CORDIC sin/cos, single-cycle
//          IEEE-754 bit-trick rsqrt/log2/ex2. Macro SFU_SINCOS_QUADRANT_EN
//          widens the sin/cos input range from [-pi/2, pi/2] to [-pi, pi].
// Rev    : 1.0
//============================================================================
module sfu (
  input  logic clk_i,
  input  logic rst_n,
  sfu_if.slave bus
);

  localparam logic [2:0] OP_SIN   = 3'b000;
  localparam logic [2:0] OP_COS   = 3'b001;
  localparam logic [2:0] OP_RSQRT = 3'b010;
  localparam logic [2:0] OP_LOG2  = 3'b011;
  localparam logic [2:0] OP_EX2   = 3'b100;

  localparam logic signed [31:0] CORDIC_K  = 32'sh136E9DB3;
  localparam logic signed [31:0] HALF_PI   = 32'sh3243F6A9;
  localparam logic signed [31:0] EX2_MIN   = 32'hC0800000;
  localparam logic signed [31:0] EX2_MAX   = 32'sh40000000;
  localparam logic        [31:0] RSQRT_MAGIC = 32'h5F3759DF;
  localparam logic        [31:0] FP_ONE    = 32'h3F800000;
  localparam logic        [31:0] FP_INF    = 32'h7F800000;
  localparam logic        [31:0] FP_QNAN   = 32'h7FC00000;
  localparam logic        [31:0] Q823_NEG_INF = 32'h80000000;
  localparam logic        [4:0]  LAST_ITER = 5'd23;
`ifdef SFU_SINCOS_QUADRANT_EN
  localparam logic signed [31:0] PI        = 32'sh6487ED51;
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic signed [31:0] x_q, x_d;
  logic signed [31:0] y_q, y_d;
  logic signed [31:0] z_q, z_d;
  logic [4:0]         iter_q, iter_d;
  logic               is_cos_q, is_cos_d;
  logic               neg_q, neg_d;
  logic [31:0]        result_q, result_d;
  logic               stall_q, stall_d;

  // atan(2^-i) in Q2.29, rounded to nearest.
  function automatic logic signed [31:0] atan_lut(input logic [4:0] idx);
    logic signed [31:0] v;
    case (idx)
      5'd0:    v = 32'sh1921FB54;
      5'd1:    v = 32'sh0ED63383;
      5'd2:    v = 32'sh07D6DD7E;
      5'd3:    v = 32'sh03FAB753;
      5'd4:    v = 32'sh01FF55BB;
      5'd5:    v = 32'sh00FFEAAE;
      5'd6:    v = 32'sh007FFD55;
      5'd7:    v = 32'sh003FFFAB;
      5'd8:    v = 32'sh001FFFF5;
      5'd9:    v = 32'sh000FFFFF;
      5'd10:   v = 32'sh00080000;
      5'd11:   v = 32'sh00040000;
      5'd12:   v = 32'sh00020000;
      5'd13:   v = 32'sh00010000;
      5'd14:   v = 32'sh00008000;
      5'd15:   v = 32'sh00004000;
      5'd16:   v = 32'sh00002000;
      5'd17:   v = 32'sh00001000;
      5'd18:   v = 32'sh00000800;
      5'd19:   v = 32'sh00000400;
      5'd20:   v = 32'sh00000200;
      5'd21:   v = 32'sh00000100;
      5'd22:   v = 32'sh00000080;
      5'd23:   v = 32'sh00000040;
      default: v = 32'sh00000000;
    endcase
    return v;
  endfunction

  logic signed [31:0] w_src;
  logic               w_is_zero;
  logic [31:0]        w_rsqrt;
  logic [31:0]        w_log2;
  logic [31:0]        w_ex2;
  logic [31:0]        w_single;

  assign w_src     = signed'(bus.src1_i);
  assign w_is_zero = (bus.src1_i[30:0] == 31'd0);

  always_comb begin
    w_rsqrt = RSQRT_MAGIC - (bus.src1_i >> 1);
    if (w_is_zero) begin
      w_rsqrt = FP_INF;
    end else if (bus.src1_i[31]) begin
      w_rsqrt = FP_QNAN;
    end

    w_log2 = {1'b0, bus.src1_i[30:0]} - FP_ONE;
    if (w_is_zero || bus.src1_i[31]) begin
      w_log2 = Q823_NEG_INF;
    end

    w_ex2 = bus.src1_i + FP_ONE;
    if (w_src < EX2_MIN) begin
      w_ex2 = 32'h00000000;
    end else if (w_src >= EX2_MAX) begin
      w_ex2 = FP_INF;
    end

    case (bus.selop_i)
      OP_RSQRT: w_single = w_rsqrt;
      OP_LOG2:  w_single = w_log2;
      OP_EX2:   w_single = w_ex2;
      default:  w_single = 32'h00000000;
    endcase
  end

  logic signed [31:0] w_z0;
  logic               w_neg0;

  always_comb begin
    w_z0   = w_src;
    w_neg0 = 1'b0;
`ifdef SFU_SINCOS_QUADRANT_EN
    // Fold into [-pi/2, pi/2]; sin/cos of (a -/+ pi) are the negated originals.
    if (w_src > HALF_PI) begin
      w_z0   = w_src - PI;
      w_neg0 = 1'b1;
    end else if (w_src < -HALF_PI) begin
      w_z0   = w_src + PI;
      w_neg0 = 1'b1;
    end
`else
    if (w_src > HALF_PI) begin
      w_z0 = HALF_PI;
    end else if (w_src < -HALF_PI) begin
      w_z0 = -HALF_PI;
    end
`endif
  end

  logic               w_dir_pos;
  logic signed [31:0] w_x_sh;
  logic signed [31:0] w_y_sh;
  logic signed [31:0] w_atan;
  logic signed [31:0] w_x_nxt;
  logic signed [31:0] w_y_nxt;
  logic signed [31:0] w_z_nxt;
  logic signed [31:0] w_cordic_raw;
  logic signed [31:0] w_cordic_res;

  assign w_dir_pos = ~z_q[31];
  assign w_x_sh    = x_q >>> iter_q;
  assign w_y_sh    = y_q >>> iter_q;
  assign w_atan    = atan_lut(iter_q);
  assign w_x_nxt   = w_dir_pos ? (x_q - w_y_sh) : (x_q + w_y_sh);
  assign w_y_nxt   = w_dir_pos ? (y_q + w_x_sh) : (y_q - w_x_sh);
  assign w_z_nxt   = w_dir_pos ? (z_q - w_atan) : (z_q + w_atan);

  assign w_cordic_raw = is_cos_q ? w_x_nxt : w_y_nxt;
  assign w_cordic_res = neg_q ? -w_cordic_raw : w_cordic_raw;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    iter_d   = iter_q;
    is_cos_d = is_cos_q;
    neg_d    = neg_q;
    result_d = result_q;
    stall_d  = stall_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          if ((bus.selop_i == OP_SIN) || (bus.selop_i == OP_COS)) begin
            x_d      = CORDIC_K;
            y_d      = 32'sh00000000;
            z_d      = w_z0;
            iter_d   = 5'd0;
            is_cos_d = (bus.selop_i == OP_COS);
            neg_d    = w_neg0;
            stall_d  = 1'b1;
            state_d  = ST_BUSY;
          end else begin
            result_d = w_single;
          end
        end
      end
      ST_BUSY: begin
        x_d    = w_x_nxt;
        y_d    = w_y_nxt;
        z_d    = w_z_nxt;
        iter_d = iter_q + 5'd1;
        if (iter_q == LAST_ITER) begin
          iter_d   = 5'd0;
          result_d = w_cordic_res;
          stall_d  = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        stall_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_n) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      iter_q   <= '0;
      is_cos_q <= 1'b0;
      neg_q    <= 1'b0;
      result_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      iter_q   <= iter_d;
      is_cos_q <= is_cos_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      stall_q  <= stall_d;
    end
  end

  assign bus.Result_o = result_q;
  assign bus.stall_o  = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_sfu.sv
`default_nettype none
//============================================================================
// Module : tb_sfu
// Desc   : Directed self-checking bench for sfu with an expected-result queue.
// Rev    : 1.0
//============================================================================
module tb_sfu;

  localparam logic [2:0] OP_SIN   = 3'b000;
  localparam logic [2:0] OP_COS   = 3'b001;
  localparam logic [2:0] OP_RSQRT = 3'b010;
  localparam logic [2:0] OP_LOG2  = 3'b011;
  localparam logic [2:0] OP_EX2   = 3'b100;

  logic clk_i = 1'b0;
  logic rst_n;

  sfu_if bus ();

  sfu dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  int          tol_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic check_tol(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                           input int tol);
    logic signed [31:0] diff;
    logic               ok;
    diff = signed'(obs - exp);
    if (diff < 0) diff = -diff;
    ok = (diff <= tol);
    n_checks++;
    assert (ok === 1'b1) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h +/-%0d", tag, obs, exp, tol);
  endtask

  task automatic check_sb(input string tag);
    logic [31:0] exp;
    int          tol;
    if (exp_q.size() == 0) begin
      n_checks++;
      $error("FAIL %s: observed empty scoreboard expected one entry", tag);
    end else begin
      exp = exp_q.pop_front();
      tol = tol_q.pop_front();
      if (tol == 0) check_val(tag, bus.Result_o, exp);
      else          check_tol(tag, bus.Result_o, exp, tol);
    end
  endtask

  task automatic do_single(input logic [2:0] op, input logic [31:0] src,
                           input logic [31:0] exp, input string tag);
    @(negedge clk_i);
    bus.start_i = 1'b1;
    bus.selop_i = op;
    bus.src1_i  = src;
    exp_q.push_back(exp);
    tol_q.push_back(0);
    @(posedge clk_i);
    #1;
    bus.start_i = 1'b0;
    check_sb(tag);
  endtask

  task automatic do_cordic(input logic [2:0] op, input logic [31:0] src,
                           input logic [31:0] exp, input int tol, input string tag,
                           input bit pulse);
    int cnt;
    @(negedge clk_i);
    bus.start_i = 1'b1;
    bus.selop_i = op;
    bus.src1_i  = src;
    exp_q.push_back(exp);
    tol_q.push_back(tol);
    @(posedge clk_i);
    #1;
    bus.start_i = 1'b0;
    // Operand lines change mid-flight; only the accepting edge may see them.
    bus.selop_i = OP_LOG2;
    bus.src1_i  = 32'h40000000;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.stall_o !== 1'b1) break;
      cnt++;
      bus.start_i = (pulse && (k == 5));
      @(posedge clk_i);
      #1;
    end
    bus.start_i = 1'b0;
    check_val({tag, " stall cycles"}, cnt, 32'd24);
    check_sb(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000ns");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n       = 1'b1;
    bus.start_i = 1'b0;
    bus.selop_i = 3'b000;
    bus.src1_i  = 32'h0;
    repeat (3) @(posedge clk_i);
    #1;
    check_val("reset result", bus.Result_o, 32'h0);
    check_val("reset stall", {31'b0, bus.stall_o}, 32'h0);
    @(negedge clk_i);
    rst_n = 1'b0;

    do_single(OP_RSQRT, 32'h3F800000, 32'h3F7759DF, "rsqrt 1.0");
    check_val("rsqrt stall", {31'b0, bus.stall_o}, 32'h0);
    do_single(OP_RSQRT, 32'h00000000, 32'h7F800000, "rsqrt +0");
    do_single(OP_RSQRT, 32'hBF800000, 32'h7FC00000, "rsqrt neg");
    do_single(OP_LOG2,  32'h40000000, 32'h00800000, "log2 2.0");
    do_single(OP_LOG2,  32'h00000000, 32'h80000000, "log2 0");
    do_single(OP_LOG2,  32'h3F800000, 32'h00000000, "log2 1.0");
    do_single(OP_EX2,   32'h00000000, 32'h3F800000, "ex2 0");
    do_single(OP_EX2,   32'h00800000, 32'h40000000, "ex2 1");
    do_single(OP_EX2,   32'hC0000000, 32'h00000000, "ex2 underflow");
    do_single(OP_EX2,   32'h40000000, 32'h7F800000, "ex2 overflow");
    do_single(3'b110,   32'h12345678, 32'h00000000, "reserved op");
    do_single(OP_EX2,   32'hC0800000, 32'h00000000, "ex2 min edge");

    bus.src1_i  = 32'h00800000;
    bus.selop_i = OP_EX2;
    @(posedge clk_i);
    #1;
    check_val("result hold", bus.Result_o, 32'h00000000);

    do_cordic(OP_SIN, 32'h00000000, 32'h00000000, 64, "sin 0", 1'b1);
    @(posedge clk_i);
    #1;
    check_val("busy pulse ignored", {31'b0, bus.stall_o}, 32'h0);
    do_cordic(OP_COS, 32'h00000000, 32'h20000000, 64, "cos 0", 1'b0);
`ifdef SFU_SINCOS_QUADRANT_EN
    do_cordic(OP_COS, 32'h6487ED51, 32'hE0000000, 64, "cos pi", 1'b0);
`else
    do_cordic(OP_COS, 32'h6487ED51, 32'h00000000, 64, "cos pi clamped", 1'b0);
`endif
    do_cordic(OP_SIN, 32'h3243F6A9, 32'h20000000, 64, "sin pi/2", 1'b0);

    // Abort a sin at its tenth busy cycle.
    @(negedge clk_i);
    bus.start_i = 1'b1;
    bus.selop_i = OP_SIN;
    bus.src1_i  = 32'h3243F6A9;
    @(posedge clk_i);
    #1;
    bus.start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    @(negedge clk_i);
    rst_n = 1'b1;
    @(posedge clk_i);
    #1;
    check_val("abort stall", {31'b0, bus.stall_o}, 32'h0);
    check_val("abort result", bus.Result_o, 32'h0);
    @(negedge clk_i);
    rst_n = 1'b0;
    repeat (30) @(posedge clk_i);
    #1;
    check_val("abort no late result", bus.Result_o, 32'h0);
    do_single(OP_LOG2, 32'h3F800000, 32'h00000000, "log2 after abort");
    do_single(OP_LOG2, 32'h40000000, 32'h00800000, "log2 2.0 after abort");

    check_val("scoreboard drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sfu.md
# sfu

Special function unit for the core's SIMT datapath. It evaluates one of five transcendental approximations on a 32-bit operand: sin, cos, rsqrt, log2 and ex2. sin/cos use an iterative 24-step CORDIC and hold `stall_o` high while busy. rsqrt/log2/ex2 are single-cycle IEEE-754 bit-manipulation approximations.

## Interface
- No parameters.
- `clk_i` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: synchronous, active-high reset (asserted = 1, despite the name).
- `start_i` in 1: launch request; sampled on the rising edge when idle.
- `src1_i` in 32: operand; format depends on `selop_i`.
- `selop_i` in 3: operation select. 000 sin, 001 cos, 010 rsqrt, 011 log2, 100 ex2, 101–111 reserved.
- `Result_o` out 32: registered result; held until the next accepted operation.
- `stall_o` out 1: registered; high while a CORDIC operation is in flight.

## Operation
- FSM states:
  - IDLE: `start_i`=1 with sin/cos → load CORDIC, go to BUSY. Any other op → write `Result_o` this edge, stay IDLE.
  - BUSY: runs iterations 0..23, one per edge. After the last iteration it writes `Result_o` and returns to IDLE.
- `start_i` is ignored in BUSY. `src1_i` and `selop_i` are sampled only on the accepting edge.
- sin/cos:
  - Operand: signed Q2.29 radians (pi/2 = 0x3243F6A9). Result: signed Q2.29 (1.0 = 0x20000000).
  - Initial values: x0 = 0x136E9DB3 (CORDIC gain K), y0 = 0, z0 = angle.
  - Each iteration: d = (z ≥ 0) ? +1 : −1. x' = x − d·(y>>>i), y' = y + d·(x>>>i), z' = z − d·atan(2^−i).
  - atan(2^−i) is a 24-entry Q2.29 constant table, i = 0..23.
  - sin returns y; cos returns x.
  - Operands outside the supported range: see Configuration.
- rsqrt (IEEE single in, single out):
  - Positive nonzero input → 0x5F3759DF − (src1 >> 1).
  - ±0 → 0x7F800000.
  - Negative input → 0x7FC00000.
- log2 (IEEE single in, signed Q8.23 out):
  - Positive nonzero input → {1'b0, src1[30:0]} − 0x3F800000.
  - Zero or negative input → 0x80000000.
- ex2 (signed Q8.23 in, IEEE single out):
  - In range → src1 + 0x3F800000.
  - src1 < −127.0 (signed < 0xC0800000) → 0x00000000.
  - src1 ≥ 128.0 (≥ 0x40000000) → 0x7F800000.
- Reserved `selop_i` codes → `Result_o` = 0, single cycle.
- All datapath arithmetic is 32-bit two's complement. Shifts are arithmetic. Intermediate overflow wraps.

## Timing
- Reset (`rst_n`=1 at an edge): `Result_o`=0, `stall_o`=0, FSM=IDLE, CORDIC registers cleared. Reset during BUSY aborts the operation; no result is written.
- Single-cycle ops: start accepted at edge E0; `Result_o` valid after E0; `stall_o` stays 0.
- sin/cos:
  - Start accepted at E0; `stall_o` rises after E0.
  - Iterations execute on E1..E24.
  - At E24, `Result_o` is updated and `stall_o` falls, so `stall_o` is high for exactly 24 cycles.
  - The first edge at which a new start is accepted is E25.
- `start_i` held high in IDLE re-launches on every edge (single-cycle ops) or immediately after completion (sin/cos).

## Configuration
- `SFU_SINCOS_QUADRANT_EN` defined:
  - sin/cos accept [−pi, pi] (pi = 0x6487ED51).
  - If angle > pi/2: z0 = angle − pi, and both outputs are negated at completion.
  - If angle < −pi/2: z0 = angle + pi, and both outputs are negated at completion.
  - Same 24-cycle latency.
- Not defined: angles outside [−pi/2, pi/2] are clamped to ±0x3243F6A9 before loading.

## Test plan
- Reset, then rsqrt on 0x3F800000 → `Result_o`=0x3F7759DF one cycle after start; `stall_o` stays 0. rsqrt on 0x00000000 → 0x7F800000. rsqrt on 0xBF800000 → 0x7FC00000.
- log2 on 0x3F800000 → 0x00000000. log2 on 0x40000000 → 0x00800000. log2 on 0x00000000 → 0x80000000.
- ex2 on 0x00000000 → 0x3F800000. ex2 on 0x00800000 → 0x40000000. ex2 on 0x40000000 → 0x7F800000. ex2 on 0xC0000000 → 0x00000000.
- sin and cos of 0x00000000:
  - `stall_o` is high for exactly 24 cycles.
  - sin → 0x00000000 ±64 LSB; cos → 0x20000000 ±64 LSB.
  - A start pulse issued while busy is ignored.
- sin of 0x3243F6A9 → 0x20000000 ±64 LSB.
  - With `SFU_SINCOS_QUADRANT_EN`: cos of 0x6487ED51 → 0xE0000000 ±64 LSB.
  - Without the macro: the same input is clamped, giving cos ≈ 0x00000000 ±64 LSB.
- Assert reset at cycle 10 of a sin operation → `stall_o`=0 and `Result_o`=0 next cycle. A following log2 on 0x3F800000 completes normally with 0x00000000.
